// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_pkg : shared word width, kernel size and feeder FSM encoding
// Revision : 1.0
// ----------------------------------------------------------------------------
package conv_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int KERNEL_SIZE = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_ROW0  = 3'd2,
    S_LPAD  = 3'd3,
    S_BODY  = 3'd4,
    S_RPAD  = 3'd5,
    S_FLUSH = 3'd6,
    S_DRAIN = 3'd7
  } conv_state_e;

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_line_buffer : two IMG_W-deep rows (i-2 on top, i-1 in the middle)
// Revision : 1.0
// ----------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int IMG_W      = 32,
  parameter int AW         = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  clr_top,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rd_top,
  output logic [DATA_WIDTH-1:0] rd_mid
);

  logic [DATA_WIDTH-1:0] top_mem [IMG_W];
  logic [DATA_WIDTH-1:0] mid_mem [IMG_W];

  assign rd_top = top_mem[addr];
  assign rd_mid = mid_mem[addr];

  // A write shifts one column up a row; clr_top zero-fills the top row during row 0.
  always_ff @(posedge clk) begin
    if (we) begin
      top_mem[addr] <= clr_top ? '0 : mid_mem[addr];
      mid_mem[addr] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv3_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv3_feeder : streams kernel then padded 3-row image columns to a conv engine
// Revision : 1.0
// ----------------------------------------------------------------------------
module conv3_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] col0,
  output logic [DATA_WIDTH-1:0] col1,
  output logic [DATA_WIDTH-1:0] col2,
  output logic                  col_valid,
  output logic                  k_load,
  output logic                  res_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W + 1);
  localparam logic [RW-1:0] ROWS     = RW'(IMG_H);
  localparam logic [1:0]    KLAST    = 2'(KERNEL_SIZE - 1);

  conv_state_e           state_q, state_d;
  logic [1:0]            ksub_q, ksub_d, kcol_q, kcol_d, dcnt_q, dcnt_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] k0_q, k0_d, k1_q, k1_d;
  logic [DATA_WIDTH-1:0] col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic                  col_valid_q, col_valid_d, k_load_q, k_load_d;
  logic                  win_q, win_d, res_p1_q, res_valid_q, done_q, done_d;
  logic                  lb_we, lb_clr;
  logic [AW-1:0]         lb_addr;
  logic [DATA_WIDTH-1:0] lb_top, lb_mid;
  logic                  accept;

  assign s_ready = (state_q == S_KLOAD) || (state_q == S_ROW0) || (state_q == S_BODY);
  assign busy    = (state_q != S_IDLE);
  assign accept  = s_valid && s_ready;

  conv_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .AW         (AW)
  ) u_lbuf (
    .clk     (clk),
    .we      (lb_we),
    .clr_top (lb_clr),
    .addr    (lb_addr),
    .din     (s_data),
    .rd_top  (lb_top),
    .rd_mid  (lb_mid)
  );

  always_comb begin
    state_d     = state_q;
    ksub_d      = ksub_q;
    kcol_d      = kcol_q;
    dcnt_d      = dcnt_q;
    col_d       = col_q;
    row_d       = row_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    col0_d      = '0;
    col1_d      = '0;
    col2_d      = '0;
    col_valid_d = 1'b0;
    k_load_d    = 1'b0;
    win_d       = 1'b0;
    done_d      = 1'b0;
    lb_we       = 1'b0;
    lb_clr      = 1'b0;
    lb_addr     = col_q[AW-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_KLOAD;
          ksub_d  = '0;
          kcol_d  = '0;
        end
      end
      S_KLOAD: begin
        if (accept) begin
          if (ksub_q == 2'd0) k0_d = s_data;
          if (ksub_q == 2'd1) k1_d = s_data;
          if (ksub_q == KLAST) begin
            col_valid_d = 1'b1;
            k_load_d    = 1'b1;
            col0_d      = k0_q;
            col1_d      = k1_q;
            col2_d      = s_data;
            ksub_d      = '0;
            kcol_d      = kcol_q + 2'd1;
            if (kcol_q == KLAST) begin
              state_d = S_ROW0;
              col_d   = '0;
            end
          end else begin
            ksub_d = ksub_q + 2'd1;
          end
        end
      end
      S_ROW0: begin
        if (accept) begin
          lb_we  = 1'b1;
          lb_clr = 1'b1;
          if (col_q == LAST_PIX) begin
            state_d = S_LPAD;
            col_d   = '0;
            row_d   = RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_LPAD: begin
        col_valid_d = 1'b1;
        state_d     = S_BODY;
      end
      S_BODY: begin
        if (accept) begin
          lb_we       = 1'b1;
          col_valid_d = 1'b1;
          col0_d      = lb_top;
          col1_d      = lb_mid;
          col2_d      = s_data;
          win_d       = (col_q != '0);
          if (col_q == LAST_PIX) begin
            state_d = S_RPAD;
            col_d   = '0;
            row_d   = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_RPAD: begin
        col_valid_d = 1'b1;
        win_d       = 1'b1;
        state_d     = (row_q == ROWS) ? S_FLUSH : S_LPAD;
        col_d       = '0;
      end
      S_FLUSH: begin
        // Here col_q is the emitted column index c, so pixel j = c-1.
        col_valid_d = 1'b1;
        col_d       = col_q + CW'(1);
        lb_addr     = AW'(col_q - CW'(1));
        if (col_q == LAST_COL) begin
          win_d   = 1'b1;
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else if (col_q != '0) begin
          col0_d = lb_top;
          col1_d = lb_mid;
          win_d  = (col_q >= CW'(2));
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd2) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ksub_q      <= '0;
      kcol_q      <= '0;
      dcnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
      col2_q      <= '0;
      col_valid_q <= 1'b0;
      k_load_q    <= 1'b0;
      win_q       <= 1'b0;
      res_p1_q    <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ksub_q      <= ksub_d;
      kcol_q      <= kcol_d;
      dcnt_q      <= dcnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      col2_q      <= col2_d;
      col_valid_q <= col_valid_d;
      k_load_q    <= k_load_d;
      win_q       <= win_d;
      res_p1_q    <= win_q;
      res_valid_q <= res_p1_q;
      done_q      <= done_d;
    end
  end

  assign col0      = col0_q;
  assign col1      = col1_q;
  assign col2      = col2_q;
  assign col_valid = col_valid_q;
  assign k_load    = k_load_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv3_feeder : directed bench for conv3_feeder at IMG_W=4, IMG_H=3
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_conv3_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] col0, col1, col2;
  logic        col_valid, k_load, res_valid, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        log_k [$];
  logic [15:0] log_c0 [$];
  logic [15:0] log_c1 [$];
  logic [15:0] log_c2 [$];
  int          log_cyc [$];
  int          res_cyc [$];
  int          done_cyc [$];

  // Kernel columns, then row 1, row 2 and the flush row, each padded both sides.
  int EXP_K  [21] = '{1,1,1, 0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0};
  int EXP_C0 [21] = '{1,4,7, 0,0,0,0,0,0, 0,1,2,3,4,0, 0,5,6,7,8,0};
  int EXP_C1 [21] = '{2,5,8, 0,1,2,3,4,0, 0,5,6,7,8,0, 0,9,10,11,12,0};
  int EXP_C2 [21] = '{3,6,9, 0,5,6,7,8,0, 0,9,10,11,12,0, 0,0,0,0,0,0};

  conv3_feeder #(
    .DATA_WIDTH  (16),
    .IMG_W       (4),
    .IMG_H       (3),
    .KERNEL_SIZE (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .col0      (col0),
    .col1      (col1),
    .col2      (col2),
    .col_valid (col_valid),
    .k_load    (k_load),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (col_valid) begin
        log_k.push_back(k_load);
        log_c0.push_back(col0);
        log_c1.push_back(col1);
        log_c2.push_back(col2);
        log_cyc.push_back(cyc);
      end
      if (res_valid) res_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    log_k.delete(); log_c0.delete(); log_c1.delete(); log_c2.delete();
    log_cyc.delete(); res_cyc.delete(); done_cyc.delete();
  endtask

  // Offer one word from a negedge; s_ready is stable there, so it decides acceptance.
  task automatic send(input int w);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    s_data  = 16'(w);
    s_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = s_ready;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout word=%0d s_ready never seen", w);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, col_valid, k_load, res_valid, busy, done} !== 6'b0)
      begin bad++; $display("FAIL reset_ctrl got=%b exp=000000",
                            {s_ready, col_valid, k_load, res_valid, busy, done}); end
    total++;
    if ({col0, col1, col2} !== 48'h0)
      begin bad++; $display("FAIL reset_cols got=%h exp=0", {col0, col1, col2}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, s_ready} !== 2'b00)
      begin bad++; $display("FAIL idle_after_reset busy,s_ready got=%b exp=00", {busy, s_ready}); end
  endtask

  // mode 0: plain job; mode 1: 3-cycle stall after pixel 6; mode 2: start pulsed while busy.
  task automatic test_job(input int mode, input string name);
    int n, m, exp_res [$];
    clear_logs();
    pulse_start();
    for (int w = 1; w <= 9; w++) send(w);
    for (int p = 1; p <= 12; p++) begin
      if (mode == 2 && p == 3) start = 1'b1;
      send(p);
      start = 1'b0;
      if (mode == 1 && p == 6) begin
        for (int s = 0; s < 3; s++) begin
          total++;
          if (s_ready !== 1'b1)
            begin bad++; $display("FAIL %s stall_ready got=%b exp=1", name, s_ready); end
          @(negedge clk);
          total++;
          if (col_valid !== 1'b0)
            begin bad++; $display("FAIL %s stall_col got=%b exp=0", name, col_valid); end
        end
      end
    end
    n = 0;
    while (done_cyc.size() == 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    if (mode == 2) repeat (10) @(negedge clk);

    total++;
    if (log_k.size() != 21)
      begin bad++; $display("FAIL %s col_count got=%0d exp=21", name, log_k.size()); end
    m = (log_k.size() < 21) ? log_k.size() : 21;
    for (int i = 0; i < m; i++) begin
      total++;
      if ({log_k[i], log_c0[i], log_c1[i], log_c2[i]} !==
          {EXP_K[i] != 0, 16'(EXP_C0[i]), 16'(EXP_C1[i]), 16'(EXP_C2[i])})
        begin bad++;
          $display("FAIL %s col[%0d] got k=%0d {%0d,%0d,%0d} exp k=%0d {%0d,%0d,%0d}", name, i,
                   log_k[i], log_c0[i], log_c1[i], log_c2[i],
                   EXP_K[i], EXP_C0[i], EXP_C1[i], EXP_C2[i]);
        end
    end

    for (int i = 3; i < m; i++)
      if (((i - 3) % 6) >= 2) exp_res.push_back(log_cyc[i] + 2);
    total++;
    if (res_cyc.size() != 12)
      begin bad++; $display("FAIL %s res_count got=%0d exp=12", name, res_cyc.size()); end
    for (int i = 0; i < exp_res.size() && i < res_cyc.size(); i++) begin
      total++;
      if (res_cyc[i] != exp_res[i])
        begin bad++; $display("FAIL %s res_time[%0d] got=%0d exp=%0d", name, i, res_cyc[i], exp_res[i]); end
    end

    total++;
    if (done_cyc.size() != 1)
      begin bad++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cyc.size()); end
    else if (res_cyc.size() > 0) begin
      total++;
      if (done_cyc[0] < res_cyc[res_cyc.size()-1])
        begin bad++; $display("FAIL %s done_order got=%0d exp>=%0d", name, done_cyc[0],
                              res_cyc[res_cyc.size()-1]); end
    end
    total++;
    if (busy !== 1'b0)
      begin bad++; $display("FAIL %s busy_end got=%b exp=0", name, busy); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start();
    for (int w = 1; w <= 9; w++) send(w);
    for (int p = 1; p <= 6; p++) send(p);
    total++;
    if ({col_valid, col0, col1, col2} !== {1'b1, 16'd0, 16'd2, 16'd6})
      begin bad++; $display("FAIL mid_pre_reset_col got=%b {%0d,%0d,%0d} exp=1 {0,2,6}",
                            col_valid, col0, col1, col2); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, col_valid, k_load, res_valid, busy, done} !== 6'b0)
      begin bad++; $display("FAIL mid_async_ctrl got=%b exp=000000",
                            {s_ready, col_valid, k_load, res_valid, busy, done}); end
    total++;
    if ({col0, col1, col2} !== 48'h0)
      begin bad++; $display("FAIL mid_async_cols got=%h exp=0", {col0, col1, col2}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({busy, res_valid, col_valid} !== 3'b000)
        begin bad++; $display("FAIL mid_idle busy,res,col got=%b exp=000", {busy, res_valid, col_valid}); end
    end
    total++;
    if (done_cyc.size() != 0)
      begin bad++; $display("FAIL mid_no_done got=%0d exp=0", done_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_job(0, "basic");
    test_job(1, "stall");
    test_reset_mid();
    test_job(0, "after_reset");
    test_job(2, "busy_start");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
